// File: rtl/pin_lock_fsm.sv
// ---------------------------------------------------------------------------
// pin_lock_fsm
//
// PIN-entry lock controller. Collects PIN_LEN keypad digits one at a time and
// compares them against a runtime-programmable PIN register. Grant/deny is
// decided only after the whole sequence has been entered, so a wrong digit is
// never revealed early. Counts consecutive failures, enforces a timed lockout
// after MAX_TRIES failures and lets the PIN be reprogrammed while unlocked.
//
// Digit handshake: enter is a single-cycle strobe with no back-pressure. A
// digit is consumed on the rising edge where enter=1 and the controller is in
// ENTRY or PROG (and clear=0); in any other state the strobe is dropped.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   digit       in   keypad digit, valid when enter=1
//   enter       in   single-cycle digit strobe
//   clear       in   abort entry / relock
//   prog_en     in   request PIN programming (honoured only in OPEN)
//   unlocked    out  high while in OPEN or PROG
//   locked_out  out  high while in LOCKOUT
//   error       out  one-cycle pulse on a failed attempt
//   prog_done   out  one-cycle pulse when a new PIN is committed
//   digit_idx   out  index of the next digit expected in ENTRY/PROG
//   fail_cnt    out  consecutive failed attempts
//   state_o     out  ENTRY=0, OPEN=1, LOCKOUT=2, PROG=3
// ---------------------------------------------------------------------------
module pin_lock_fsm #(
   parameter int                            PIN_LEN        = 4,
   parameter int                            DIGIT_W        = 4,
   parameter int                            MAX_TRIES      = 3,
   parameter int                            LOCKOUT_CYCLES = 1000,
   parameter logic [PIN_LEN*DIGIT_W-1:0]    DEFAULT_PIN    = 16'h9979,
   localparam int                           IDX_W = (PIN_LEN > 1) ? $clog2(PIN_LEN) : 1,
   localparam int                           FC_W  = (MAX_TRIES > 0) ? $clog2(MAX_TRIES + 1) : 1,
   localparam int                           LC_W  = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [DIGIT_W-1:0]  digit,
   input  logic                enter,
   input  logic                clear,
   input  logic                prog_en,
   output logic                unlocked,
   output logic                locked_out,
   output logic                error,
   output logic                prog_done,
   output logic [IDX_W-1:0]    digit_idx,
   output logic [FC_W-1:0]     fail_cnt,
   output logic [2:0]          state_o
);

   localparam int PIN_W = PIN_LEN * DIGIT_W;

   typedef enum logic [2:0] {
      S_ENTRY   = 3'd0,
      S_OPEN    = 3'd1,
      S_LOCKOUT = 3'd2,
      S_PROG    = 3'd3
   } state_t;

   // state and datapath registers
   state_t              r_state;
   logic [IDX_W-1:0]    r_idx;
   logic                r_mis;
   logic [FC_W-1:0]     r_fail;
   logic [LC_W-1:0]     r_cnt;
   logic [PIN_W-1:0]    r_pin;
   logic [PIN_W-1:0]    r_shadow;

   // registered outputs
   logic                r_unlocked;
   logic                r_locked;
   logic                r_error;
   logic                r_prog_done;

   // next-state values
   state_t              w_state_nxt;
   logic [IDX_W-1:0]    w_idx_nxt;
   logic                w_mis_nxt;
   logic [FC_W-1:0]     w_fail_nxt;
   logic [LC_W-1:0]     w_cnt_nxt;
   logic [PIN_W-1:0]    w_pin_nxt;
   logic [PIN_W-1:0]    w_shadow_nxt;
   logic                w_error_nxt;
   logic                w_done_nxt;

   // helpers
   logic [DIGIT_W-1:0]  w_exp;        // stored PIN digit at the current index
   logic [PIN_W-1:0]    w_shadow_wr;  // shadow with the incoming digit merged in
   logic                w_mis_upd;    // running mismatch including this digit
   logic                w_last;       // current index is the final digit

   // Field select: index 0 is the first-entered digit, held in the MS field.
   always_comb begin
      w_exp       = '0;
      w_shadow_wr = r_shadow;
      for (int i = 0; i < PIN_LEN; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_exp = r_pin[(PIN_LEN-1-i)*DIGIT_W +: DIGIT_W];
            w_shadow_wr[(PIN_LEN-1-i)*DIGIT_W +: DIGIT_W] = digit;
         end
      end
   end

   assign w_mis_upd = r_mis | (digit != w_exp);
   assign w_last    = (r_idx == IDX_W'(PIN_LEN - 1));

   // Next-state logic. Priority within a cycle: clear > enter > prog_en.
   always_comb begin
      w_state_nxt  = r_state;
      w_idx_nxt    = r_idx;
      w_mis_nxt    = r_mis;
      w_fail_nxt   = r_fail;
      w_cnt_nxt    = r_cnt;
      w_pin_nxt    = r_pin;
      w_shadow_nxt = r_shadow;
      w_error_nxt  = 1'b0;
      w_done_nxt   = 1'b0;

      case (r_state)
         S_ENTRY: begin
            if (clear) begin
               // fail_cnt deliberately kept: clearing must not reset the tally
               w_idx_nxt = '0;
               w_mis_nxt = 1'b0;
            end else if (enter) begin
               if (w_last) begin
                  w_idx_nxt = '0;
                  w_mis_nxt = 1'b0;
                  if (!w_mis_upd) begin
                     w_state_nxt = S_OPEN;
                     w_fail_nxt  = '0;
                  end else if (r_fail == FC_W'(MAX_TRIES - 1)) begin
                     w_state_nxt = S_LOCKOUT;
                     w_error_nxt = 1'b1;
                     w_fail_nxt  = FC_W'(MAX_TRIES);
                     w_cnt_nxt   = LC_W'(LOCKOUT_CYCLES - 1);
                  end else begin
                     w_error_nxt = 1'b1;
                     w_fail_nxt  = r_fail + FC_W'(1);
                  end
               end else begin
                  w_idx_nxt = r_idx + IDX_W'(1);
                  w_mis_nxt = w_mis_upd;
               end
            end
         end

         S_OPEN: begin
            if (clear) begin
               w_state_nxt = S_ENTRY;
               w_idx_nxt   = '0;
               w_mis_nxt   = 1'b0;
            end else if (prog_en) begin
               w_state_nxt = S_PROG;
               w_idx_nxt   = '0;
            end
         end

         S_LOCKOUT: begin
            // counter was loaded with LOCKOUT_CYCLES-1, so the state lasts
            // exactly LOCKOUT_CYCLES cycles including the one where it hits 0
            if (r_cnt == '0) begin
               w_state_nxt = S_ENTRY;
               w_fail_nxt  = '0;
               w_idx_nxt   = '0;
               w_mis_nxt   = 1'b0;
            end else begin
               w_cnt_nxt = r_cnt - LC_W'(1);
            end
         end

         S_PROG: begin
            if (clear) begin
               w_state_nxt = S_ENTRY;
               w_idx_nxt   = '0;
               w_mis_nxt   = 1'b0;
            end else if (enter) begin
               w_shadow_nxt = w_shadow_wr;
               if (w_last) begin
                  // whole new PIN lands in one edge, never partially written
                  w_pin_nxt   = w_shadow_wr;
                  w_done_nxt  = 1'b1;
                  w_state_nxt = S_OPEN;
                  w_idx_nxt   = '0;
               end else begin
                  w_idx_nxt = r_idx + IDX_W'(1);
               end
            end
         end

         default: begin
            w_state_nxt = S_ENTRY;
            w_idx_nxt   = '0;
            w_mis_nxt   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_ENTRY;
         r_idx       <= '0;
         r_mis       <= 1'b0;
         r_fail      <= '0;
         r_cnt       <= '0;
         r_pin       <= DEFAULT_PIN;
         r_shadow    <= '0;
         r_unlocked  <= 1'b0;
         r_locked    <= 1'b0;
         r_error     <= 1'b0;
         r_prog_done <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_idx       <= w_idx_nxt;
         r_mis       <= w_mis_nxt;
         r_fail      <= w_fail_nxt;
         r_cnt       <= w_cnt_nxt;
         r_pin       <= w_pin_nxt;
         r_shadow    <= w_shadow_nxt;
         // flags decoded from the next state so they align with state_o
         r_unlocked  <= (w_state_nxt == S_OPEN) || (w_state_nxt == S_PROG);
         r_locked    <= (w_state_nxt == S_LOCKOUT);
         r_error     <= w_error_nxt;
         r_prog_done <= w_done_nxt;
      end
   end

   assign unlocked   = r_unlocked;
   assign locked_out = r_locked;
   assign error      = r_error;
   assign prog_done  = r_prog_done;
   assign digit_idx  = r_idx;
   assign fail_cnt   = r_fail;
   assign state_o    = r_state;

endmodule

// File: tb/tb_pin_lock_fsm.sv
module tb_pin_lock_fsm;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   // main DUT: 4 digits, default 9979, short lockout
   logic       rst_n;
   logic [3:0] digit;
   logic       enter, clear, prog_en;
   logic       unlocked, locked_out, error, prog_done;
   logic [1:0] digit_idx;
   logic [1:0] fail_cnt;
   logic [2:0] state_o;

   // second DUT: 6 digits, default 123456
   logic       d6_rst_n;
   logic [3:0] d6_digit;
   logic       d6_enter, d6_clear, d6_prog_en;
   logic       d6_unl, d6_lock, d6_err, d6_done;
   logic [2:0] d6_idx;
   logic [1:0] d6_fail;
   logic [2:0] d6_state;

   pin_lock_fsm #(
      .PIN_LEN(4), .DIGIT_W(4), .MAX_TRIES(3), .LOCKOUT_CYCLES(8),
      .DEFAULT_PIN(16'h9979)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .digit(digit), .enter(enter),
      .clear(clear), .prog_en(prog_en), .unlocked(unlocked),
      .locked_out(locked_out), .error(error), .prog_done(prog_done),
      .digit_idx(digit_idx), .fail_cnt(fail_cnt), .state_o(state_o)
   );

   pin_lock_fsm #(
      .PIN_LEN(6), .DIGIT_W(4), .MAX_TRIES(3), .LOCKOUT_CYCLES(8),
      .DEFAULT_PIN(24'h123456)
   ) u_dut6 (
      .clk(clk), .rst_n(d6_rst_n), .digit(d6_digit), .enter(d6_enter),
      .clear(d6_clear), .prog_en(d6_prog_en), .unlocked(d6_unl),
      .locked_out(d6_lock), .error(d6_err), .prog_done(d6_done),
      .digit_idx(d6_idx), .fail_cnt(d6_fail), .state_o(d6_state)
   );

   logic [10:0] w_got;
   logic [11:0] w_got6;
   assign w_got  = {state_o, unlocked, locked_out, error, prog_done, digit_idx, fail_cnt};
   assign w_got6 = {d6_state, d6_unl, d6_lock, d6_err, d6_done, d6_idx, d6_fail};

   function automatic logic [10:0] pk(input logic [2:0] st, input logic ul, lo, er, dn,
                                      input logic [1:0] idx, input logic [1:0] fc);
      return {st, ul, lo, er, dn, idx, fc};
   endfunction

   function automatic logic [11:0] pk6(input logic [2:0] st, input logic ul, lo, er, dn,
                                       input logic [2:0] idx, input logic [1:0] fc);
      return {st, ul, lo, er, dn, idx, fc};
   endfunction

   // ---------------- scoreboard ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        en;
      logic        cl;
      logic        pe;
      logic [3:0]  d;
      logic [10:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic en, cl, pe, input logic [3:0] d, input logic [10:0] exp);
      vec_t v;
      v.en = en; v.cl = cl; v.pe = pe; v.d = d; v.exp = exp;
      vecs.push_back(v);
   endtask

   // ---------------- drivers ----------------
   task automatic step(input logic en, cl, pe, input logic [3:0] d);
      enter = en; clear = cl; prog_en = pe; digit = d;
      @(posedge clk); #1;
      enter = 1'b0; clear = 1'b0; prog_en = 1'b0;
   endtask

   task automatic step6(input logic en, cl, pe, input logic [3:0] d);
      d6_enter = en; d6_clear = cl; d6_prog_en = pe; d6_digit = d;
      @(posedge clk); #1;
      d6_enter = 1'b0; d6_clear = 1'b0; d6_prog_en = 1'b0;
   endtask

   task automatic enter_pin(input logic [15:0] pin);
      for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0, pin[15-4*k -: 4]);
   endtask

   task automatic enter_pin6(input logic [23:0] pin);
      for (int k = 0; k < 6; k++) step6(1'b1, 1'b0, 1'b0, pin[23-4*k -: 4]);
   endtask

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int   locked_cnt;
      logic err_seen;
      logic cl_b, pe_b;

      rst_n = 1'b0; d6_rst_n = 1'b0;
      enter = 0; clear = 0; prog_en = 0; digit = 0;
      d6_enter = 0; d6_clear = 0; d6_prog_en = 0; d6_digit = 0;
      #1;
      check("reset_state", w_got, pk(0,0,0,0,0,0,0));
      check("reset_state6", w_got6, pk6(0,0,0,0,0,0,0));
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1; d6_rst_n = 1'b1;

      // ---- table: st ul lo er dn idx fc ----
      // correct default PIN
      add(1,0,0,4'h9, pk(0,0,0,0,0,1,0));
      add(1,0,0,4'h9, pk(0,0,0,0,0,2,0));
      add(1,0,0,4'h7, pk(0,0,0,0,0,3,0));
      add(1,0,0,4'h9, pk(1,1,0,0,0,0,0));
      add(1,0,0,4'h9, pk(1,1,0,0,0,0,0));   // enter ignored in OPEN
      add(0,1,1,4'h0, pk(0,0,0,0,0,0,0));   // clear beats prog_en
      add(0,0,1,4'h0, pk(0,0,0,0,0,0,0));   // prog_en ignored in ENTRY
      // wrong last digit
      add(1,0,0,4'h9, pk(0,0,0,0,0,1,0));
      add(1,0,0,4'h9, pk(0,0,0,0,0,2,0));
      add(1,0,0,4'h7, pk(0,0,0,0,0,3,0));
      add(1,0,0,4'h8, pk(0,0,0,1,0,0,1));
      add(0,0,0,4'h0, pk(0,0,0,0,0,0,1));
      // wrong first digit: no early reveal, same response
      add(1,0,0,4'h1, pk(0,0,0,0,0,1,1));
      add(1,0,0,4'h9, pk(0,0,0,0,0,2,1));
      add(1,0,0,4'h7, pk(0,0,0,0,0,3,1));
      add(1,0,0,4'h9, pk(0,0,0,1,0,0,2));
      add(0,0,0,4'h0, pk(0,0,0,0,0,0,2));
      // enter+clear same cycle: digit not consumed, fail_cnt kept
      add(1,0,0,4'h9, pk(0,0,0,0,0,1,2));
      add(1,1,0,4'h9, pk(0,0,0,0,0,0,2));
      add(1,0,0,4'h9, pk(0,0,0,0,0,1,2));
      add(1,0,0,4'h9, pk(0,0,0,0,0,2,2));
      add(1,0,0,4'h7, pk(0,0,0,0,0,3,2));
      add(1,0,0,4'h9, pk(1,1,0,0,0,0,0));
      // program 1234
      add(0,0,1,4'h0, pk(3,1,0,0,0,0,0));
      add(1,0,0,4'h1, pk(3,1,0,0,0,1,0));
      add(1,0,0,4'h2, pk(3,1,0,0,0,2,0));
      add(1,0,0,4'h3, pk(3,1,0,0,0,3,0));
      add(1,0,0,4'h4, pk(1,1,0,0,1,0,0));
      add(0,0,0,4'h0, pk(1,1,0,0,0,0,0));
      add(0,1,0,4'h0, pk(0,0,0,0,0,0,0));
      // old PIN now fails
      add(1,0,0,4'h9, pk(0,0,0,0,0,1,0));
      add(1,0,0,4'h9, pk(0,0,0,0,0,2,0));
      add(1,0,0,4'h7, pk(0,0,0,0,0,3,0));
      add(1,0,0,4'h9, pk(0,0,0,1,0,0,1));
      // new PIN unlocks
      add(1,0,0,4'h1, pk(0,0,0,0,0,1,1));
      add(1,0,0,4'h2, pk(0,0,0,0,0,2,1));
      add(1,0,0,4'h3, pk(0,0,0,0,0,3,1));
      add(1,0,0,4'h4, pk(1,1,0,0,0,0,0));
      // abort programming after 2 digits
      add(0,0,1,4'h0, pk(3,1,0,0,0,0,0));
      add(1,0,0,4'h5, pk(3,1,0,0,0,1,0));
      add(1,0,0,4'h6, pk(3,1,0,0,0,2,0));
      add(0,1,0,4'h0, pk(0,0,0,0,0,0,0));
      // out-of-range digit mismatches
      add(1,0,0,4'h1, pk(0,0,0,0,0,1,0));
      add(1,0,0,4'h2, pk(0,0,0,0,0,2,0));
      add(1,0,0,4'h3, pk(0,0,0,0,0,3,0));
      add(1,0,0,4'hA, pk(0,0,0,1,0,0,1));
      // PIN unchanged by the abort
      add(1,0,0,4'h1, pk(0,0,0,0,0,1,1));
      add(1,0,0,4'h2, pk(0,0,0,0,0,2,1));
      add(1,0,0,4'h3, pk(0,0,0,0,0,3,1));
      add(1,0,0,4'h4, pk(1,1,0,0,0,0,0));

      foreach (vecs[i]) begin
         step(vecs[i].en, vecs[i].cl, vecs[i].pe, vecs[i].d);
         check($sformatf("vec%0d", i), w_got, vecs[i].exp);
      end

      // ---- async reset after reprogramming: PIN reverts to 9979 ----
      #3 rst_n = 1'b0;
      #1 check("async_rst_open", w_got, pk(0,0,0,0,0,0,0));
      @(posedge clk); #1 rst_n = 1'b1;
      enter_pin(16'h9979);
      check("pin_reverted", w_got, pk(1,1,0,0,0,0,0));
      step(1'b0, 1'b1, 1'b0, 4'h0);

      // ---- lockout ----
      for (int t = 0; t < 3; t++) begin
         enter_pin(16'h0000);
         if (t < 2) check($sformatf("wrong%0d", t), w_got, pk(0,0,0,1,0,0,2'(t+1)));
         else       check("enter_lockout", w_got, pk(2,0,1,1,0,0,3));
      end
      locked_cnt = 1;
      err_seen   = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cl_b = i[0]; pe_b = i[1];
         step(1'b1, cl_b, pe_b, 4'h9);
         if (!locked_out) break;
         locked_cnt++;
         err_seen = err_seen | error;
      end
      check("lockout_len", locked_cnt, 8);
      check("lockout_err_low", {31'b0, err_seen}, 0);
      check("after_lockout", w_got, pk(0,0,0,0,0,0,0));
      enter_pin(16'h9979);
      check("unlock_after_lockout", w_got, pk(1,1,0,0,0,0,0));

      // ---- async reset mid-entry ----
      step(1'b0, 1'b1, 1'b0, 4'h0);
      step(1'b1, 1'b0, 1'b0, 4'h9);
      step(1'b1, 1'b0, 1'b0, 4'h0);
      check("mid_entry", w_got, pk(0,0,0,0,0,2,0));
      #3 rst_n = 1'b0;
      #1 check("async_rst_entry", w_got, pk(0,0,0,0,0,0,0));
      @(posedge clk); #1 rst_n = 1'b1;
      enter_pin(16'h9979);
      check("unlock_after_rst", w_got, pk(1,1,0,0,0,0,0));

      // ---- 6-digit instance ----
      for (int i = 0; i < 6; i++) begin
         step6(1'b1, 1'b0, 1'b0, 4'(i + 1));
         if (i < 5) check($sformatf("d6_idx%0d", i), w_got6, pk6(0,0,0,0,0,3'(i + 1),0));
         else       check("d6_unlock", w_got6, pk6(1,1,0,0,0,0,0));
      end
      step6(1'b0, 1'b1, 1'b0, 4'h0);
      enter_pin6(24'h123457);
      check("d6_wrong", w_got6, pk6(0,0,0,1,0,0,1));
      enter_pin6(24'h123456);
      check("d6_unlock2", w_got6, pk6(1,1,0,0,0,0,0));
      step6(1'b0, 1'b0, 1'b1, 4'h0);
      check("d6_prog", w_got6, pk6(3,1,0,0,0,0,0));
      enter_pin6(24'h654321);
      check("d6_commit", w_got6, pk6(1,1,0,0,1,0,0));
      step6(1'b0, 1'b1, 1'b0, 4'h0);
      step6(1'b1, 1'b0, 1'b0, 4'h6);
      step6(1'b1, 1'b0, 1'b0, 4'h5);
      step6(1'b1, 1'b0, 1'b0, 4'h4);
      check("d6_mid", w_got6, pk6(0,0,0,0,0,3,0));
      #3 d6_rst_n = 1'b0;
      #1 check("d6_async_rst", w_got6, pk6(0,0,0,0,0,0,0));
      @(posedge clk); #1 d6_rst_n = 1'b1;
      enter_pin6(24'h654321);
      check("d6_prog_pin_gone", w_got6, pk6(0,0,0,1,0,0,1));
      enter_pin6(24'h123456);
      check("d6_default_back", w_got6, pk6(1,1,0,0,0,0,0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pin_lock_fsm.md
Name: pin_lock_fsm

Overview:
Sequential, parametrised PIN-entry lock controller and the successor to the fixed 4-digit combinational digit comparator. It collects PIN_LEN digits one at a time and compares them against a runtime-programmable PIN register. It grants or denies unlock only after the full sequence, so it never reveals which digit was wrong. It counts failed attempts, enforces a timed lockout, and allows PIN reprogramming while unlocked. It sits between the keypad/debounce front end and the display/actuator logic.

Parameters:
PIN_LEN, 4, number of digits per PIN (>=1)
DIGIT_W, 4, bits per digit
MAX_TRIES, 3, consecutive failed attempts before lockout (>=1)
LOCKOUT_CYCLES, 1000, clock cycles spent in lockout (>=1)
DEFAULT_PIN, 16'h9979, reset PIN, PIN_LEN*DIGIT_W bits; first-entered digit in the most significant field

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
digit  in  DIGIT_W  keypad digit, valid when enter=1
enter  in  1  single-cycle digit strobe
clear  in  1  abort entry / relock
prog_en  in  1  request PIN programming (honoured only in OPEN)
unlocked  out  1  high while in OPEN or PROG
locked_out  out  1  high while in LOCKOUT
error  out  1  one-cycle pulse on a failed attempt
prog_done  out  1  one-cycle pulse when a new PIN is committed
digit_idx  out  clog2(PIN_LEN) (min 1)  index of the next digit expected in ENTRY/PROG
fail_cnt  out  clog2(MAX_TRIES+1)  consecutive failed attempts
state_o  out  3  ENTRY=0, OPEN=1, LOCKOUT=2, PROG=3

Behaviour:
- Reset (async assert, sync release): state=ENTRY, pin_reg=DEFAULT_PIN, digit_idx=0, mismatch=0, fail_cnt=0, lockout counter=0. All outputs are low/zero except state_o=0.
- All outputs are registered; every input is sampled on the rising edge of clk.
- ENTRY, enter=1:
  - mismatch |= (digit != pin_reg field[digit_idx]); digit_idx++.
  - On the last digit (digit_idx==PIN_LEN-1), decide using the updated mismatch. Next cycle: digit_idx=0, mismatch=0.
  - Pass: state=OPEN, fail_cnt=0.
  - Fail with fail_cnt+1 < MAX_TRIES: stay in ENTRY, fail_cnt++, error=1 for one cycle.
  - Fail with fail_cnt+1 == MAX_TRIES: state=LOCKOUT, error=1 for one cycle, fail_cnt=MAX_TRIES, counter loaded with LOCKOUT_CYCLES-1.
- ENTRY, clear=1: digit_idx=0, mismatch=0; fail_cnt is unchanged (clear cannot be used to dodge the counter).
- LOCKOUT:
  - locked_out=1 for exactly LOCKOUT_CYCLES cycles. Counter decrements each cycle; at 0 the next state is ENTRY with fail_cnt=0.
  - enter, clear and prog_en are ignored.
- OPEN: unlocked=1.
  - clear=1 -> ENTRY (relock).
  - prog_en=1 (and clear=0) -> PROG, digit_idx=0.
  - enter is ignored.
- PROG: unlocked=1.
  - Each enter writes digit into a shadow register at field digit_idx; digit_idx++.
  - On the last digit, pin_reg <= shadow (atomic commit), prog_done=1 for one cycle, state=OPEN.
  - clear=1 aborts: shadow is discarded, pin_reg is unchanged, state=ENTRY.
- Priority within a cycle: clear > enter > prog_en.
- digit_idx wraps to 0 only via decision, commit, abort or clear; it never exceeds PIN_LEN-1.
- Reset mid-operation: immediate return to reset values; a programmed PIN reverts to DEFAULT_PIN.
- Digit comparison is exact and DIGIT_W bits wide; out-of-range values (e.g. 4'hA) simply mismatch.

Test Plan:
1. Defaults, enter 9,9,7,9 -> cycle after the 4th enter: unlocked=1, state_o=1, fail_cnt=0, error never asserted.
2. Enter 9,9,7,8 -> error pulses for 1 cycle, fail_cnt=1, state_o=0, unlocked=0; wrong first digit 1,9,7,9 gives the identical response (no early reveal).
3. LOCKOUT_CYCLES=8, three wrong PINs -> locked_out high exactly 8 cycles, enters during lockout ignored, then state_o=0 and fail_cnt=0; correct PIN then unlocks.
4. Unlocked, pulse prog_en, enter 1,2,3,4 -> prog_done pulse, state_o=1; clear -> ENTRY; 9,9,7,9 fails; 1,2,3,4 unlocks.
5. In PROG after 2 digits, assert clear -> state_o=0, PIN still 9979; enter and clear in the same cycle during ENTRY -> digit_idx=0, digit not consumed.
6. Assert rst_n low asynchronously mid-entry and after reprogramming -> outputs zero immediately, pin reverts to 9979; repeat with PIN_LEN=6, DIGIT_W=4, DEFAULT_PIN=24'h123456.
